eth_dma_wbuf: RTL and testbench

ETH_DMA_WBUF -- requirements
Module: eth_dma_wbuf

---
 rtl/eth_dma_wbuf.sv | 102 ++++++++++
 tb/tb_eth_dma_wbuf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_dma_wbuf.sv
// Posted-write buffer between a MAC DMA port and an Avalon-MM master.
// Writes are acknowledged into a FIFO; reads wait for the FIFO to drain first.
module eth_dma_wbuf #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] s_address,
   input  logic [3:0]  s_byteenable,
   input  logic        s_we,
   input  logic        s_stb,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic        s_ack,
   output logic [31:0] m_address,
   output logic [3:0]  m_byteenable,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   output logic        wbuf_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [1:0] {IDLE, DRAIN, READ, RACK} state_t;

   state_t         state, state_nxt;
   logic [31:0]    fifo_addr [DEPTH];
   logic [3:0]     fifo_be   [DEPTH];
   logic [31:0]    fifo_data [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic [31:0]    rd_addr;
   logic [3:0]     rd_be;
   logic           new_req, push, pop, last_pop, start_read;

   // A strobe seen while s_ack is high belongs to the transfer just acknowledged.
   assign new_req    = s_stb & ~s_ack;
   assign push       = new_req & s_we & (state == IDLE) & (count < DEPTH_C);
   assign start_read = new_req & ~s_we & (state == IDLE);
   assign m_write    = (count != '0) & ((state == IDLE) | (state == DRAIN));
   assign m_read     = (state == READ);
   assign pop        = m_write & ~m_waitrequest;
   assign last_pop   = pop & (count == ONE_C);
   assign wbuf_empty = (count == '0);

   // Outputs derive only from registered state, so they hold under waitrequest.
   assign m_address    = m_read ? rd_addr : fifo_addr[rd_ptr];
   assign m_byteenable = m_read ? rd_be   : fifo_be[rd_ptr];
   assign m_writedata  = fifo_data[rd_ptr];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_read) state_nxt = (count == '0) ? READ : DRAIN;
         DRAIN: if (last_pop || count == '0) state_nxt = READ;
         READ:  if (!m_waitrequest) state_nxt = RACK;
         RACK:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         s_ack      <= 1'b0;
         s_readdata <= '0;
         rd_addr    <= '0;
         rd_be      <= '0;
      end else begin
         state <= state_nxt;
         s_ack <= push | (m_read & ~m_waitrequest);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (start_read) begin
            rd_addr <= s_address;
            rd_be   <= s_byteenable;
         end
         if (m_read && !m_waitrequest) s_readdata <= m_readdata;
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= s_address;
         fifo_be[wr_ptr]   <= s_byteenable;
         fifo_data[wr_ptr] <= s_writedata;
      end
   end

endmodule

// File: tb/tb_eth_dma_wbuf.sv
// Directed bench for eth_dma_wbuf with an Avalon-side monitor and write scoreboard.
module tb_eth_dma_wbuf;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] s_address;
   logic [3:0]  s_byteenable;
   logic        s_we;
   logic        s_stb;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   logic        s_ack;
   logic [31:0] m_address;
   logic [3:0]  m_byteenable;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
   logic        wbuf_empty;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   logic [67:0] exp_q[$];

   eth_dma_wbuf #(.DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_we(s_we),
      .s_stb(s_stb), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_ack(s_ack), .m_address(m_address), .m_byteenable(m_byteenable),
      .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
      .wbuf_empty(wbuf_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] data);
      s_we = we; s_address = addr; s_byteenable = be; s_writedata = data; s_stb = 1'b1;
   endtask

   // Waits up to budget edges for s_ack; on ack the strobe is released.
   task automatic wait_ack(input int budget, output logic got, output int n);
      got = 1'b0;
      n = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         n++;
         if (s_ack) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         if (s_we) exp_q.push_back({s_address, s_byteenable, s_writedata});
         s_stb = 1'b0;
      end
   endtask

   task automatic mac_write(input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input string tag);
      logic got;
      int n;
      start_req(1'b1, addr, be, data);
      wait_ack(4, got, n);
      chk(tag, got, 1'b1);
   endtask

   task automatic wait_empty(input int budget, input string tag);
      logic seen;
      seen = wbuf_empty;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = wbuf_empty;
      end
      chk(tag, seen, 1'b1);
   endtask

   // Avalon monitor: exclusivity, stability under waitrequest, ack pulse, write order.
   logic [69:0] prev_bus;
   logic        prev_hold = 1'b0;
   logic        prev_ack  = 1'b0;
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("rw_exclusive", m_read & m_write, 1'b0);
         if (prev_hold) chk("stable_wait", {m_address, m_byteenable, m_writedata, m_read, m_write}, prev_bus);
         if (prev_ack) chk("ack_pulse", s_ack, 1'b0);
         if (m_read) chk("read_after_writes", exp_q.size(), 0);
         if (m_write && !m_waitrequest) begin
            wr_seen++;
            if (exp_q.size() == 0) chk("wr_unexpected", 1'b1, 1'b0);
            else chk("wr_order", {m_address, m_byteenable, m_writedata}, exp_q.pop_front());
         end
         prev_bus  = {m_address, m_byteenable, m_writedata, m_read, m_write};
         prev_hold = (m_read | m_write) & m_waitrequest;
         prev_ack  = s_ack;
      end else begin
         prev_hold = 1'b0;
         prev_ack  = 1'b0;
      end
   end

   initial begin
      logic got;
      int n;
      int wr_before;
      reset_n = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_address = '0; s_byteenable = '0;
      s_writedata = '0; m_readdata = '0; m_waitrequest = 1'b0;
      repeat (3) tick();
      chk("rst_ack", s_ack, 1'b0);
      chk("rst_mwrite", m_write, 1'b0);
      chk("rst_mread", m_read, 1'b0);
      chk("rst_empty", wbuf_empty, 1'b1);
      chk("rst_rdata", s_readdata, 32'h0);
      reset_n = 1'b1;
      tick();

      // Single write: ack and Avalon write one cycle after the request edge.
      start_req(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
      tick();
      chk("w1_ack", s_ack, 1'b1);
      chk("w1_mwrite", m_write, 1'b1);
      chk("w1_addr", m_address, 32'h100);
      chk("w1_data", m_writedata, 32'hDEADBEEF);
      chk("w1_be", m_byteenable, 4'hF);
      exp_q.push_back({32'h100, 4'hF, 32'hDEADBEEF});
      s_stb = 1'b0;
      tick();
      chk("w1_empty", wbuf_empty, 1'b1);
      chk("w1_ack_low", s_ack, 1'b0);

      // Fill to DEPTH under waitrequest; fifth write held off.
      m_waitrequest = 1'b1;
      mac_write(32'h1000, 4'h1, 32'h11111111, "fill_ack0");
      mac_write(32'h1004, 4'h3, 32'h22222222, "fill_ack1");
      mac_write(32'h1008, 4'h7, 32'h33333333, "fill_ack2");
      mac_write(32'h100C, 4'hC, 32'h44444444, "fill_ack3");
      start_req(1'b1, 32'h1010, 4'hF, 32'h55555555);
      wait_ack(4, got, n);
      chk("full_no_ack", got, 1'b0);
      chk("full_not_empty", wbuf_empty, 1'b0);
      m_waitrequest = 1'b0;
      wait_ack(6, got, n);
      chk("full_retry_ack", got, 1'b1);
      chk("full_retry_cycles", n, 2);
      wait_empty(20, "fill_drained");
      chk("fill_q_empty", exp_q.size(), 0);

      // Two buffered writes ahead of a read.
      m_waitrequest = 1'b1;
      mac_write(32'h2000, 4'hF, 32'hA5A5A5A5, "ord_w0");
      mac_write(32'h2004, 4'hF, 32'h5A5A5A5A, "ord_w1");
      m_readdata = 32'h12345678;
      start_req(1'b0, 32'h200, 4'hF, 32'h0);
      tick();
      chk("ord_no_read0", {m_read, m_write}, 2'b01);
      tick();
      chk("ord_no_read1", {m_read, m_write}, 2'b01);
      m_waitrequest = 1'b0;
      wait_ack(10, got, n);
      chk("ord_ack", got, 1'b1);
      chk("ord_rdata", s_readdata, 32'h12345678);
      tick();
      chk("ord_ack_once", s_ack, 1'b0);
      chk("ord_rdata_hold", s_readdata, 32'h12345678);

      // Zero-wait read latency from an empty FIFO.
      m_readdata = 32'hCAFEF00D;
      start_req(1'b0, 32'h240, 4'h3, 32'h0);
      tick();
      chk("lat_mread", m_read, 1'b1);
      chk("lat_addr", m_address, 32'h240);
      chk("lat_be", m_byteenable, 4'h3);
      m_readdata = 32'h0BADF00D;
      tick();
      chk("lat_ack", s_ack, 1'b1);
      chk("lat_rdata", s_readdata, 32'h0BADF00D);
      s_stb = 1'b0;
      tick();

      // Read with three wait states.
      m_waitrequest = 1'b1;
      m_readdata = 32'h87654321;
      start_req(1'b0, 32'h300, 4'hF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws_mread", m_read, 1'b1);
         chk("ws_addr", m_address, 32'h300);
         chk("ws_no_ack", s_ack, 1'b0);
      end
      tick();
      chk("ws_mread_last", m_read, 1'b1);
      m_waitrequest = 1'b0;
      tick();
      chk("ws_ack", s_ack, 1'b1);
      chk("ws_rdata", s_readdata, 32'h87654321);
      s_stb = 1'b0;
      tick();

      // Reset with three writes stuck behind waitrequest.
      m_waitrequest = 1'b1;
      mac_write(32'h4000, 4'hF, 32'h01010101, "rst_w0");
      mac_write(32'h4004, 4'hF, 32'h02020202, "rst_w1");
      mac_write(32'h4008, 4'hF, 32'h03030303, "rst_w2");
      tick();
      chk("pre_rst_mwrite", m_write, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("async_mwrite", m_write, 1'b0);
      chk("async_empty", wbuf_empty, 1'b1);
      chk("async_rdata", s_readdata, 32'h0);
      exp_q.delete();
      wr_before = wr_seen;
      tick();
      reset_n = 1'b1;
      m_waitrequest = 1'b0;
      repeat (5) tick();
      chk("post_rst_no_write", wr_seen, wr_before);
      chk("post_rst_mwrite", m_write, 1'b0);
      chk("post_rst_mread", m_read, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
